// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller: light codes and phase encoding.
package traffic_pkg;

    localparam logic [4:0] RED       = 5'b10000;
    localparam logic [4:0] RED_LEFT  = 5'b10100;
    localparam logic [4:0] GREEN_ALL = 5'b00111;
    localparam logic [4:0] AMBER     = 5'b01000;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_AMBER   = 2'd2
    } phase_e;

    function automatic logic [4:0] red_code(input logic free_left);
        return free_left ? RED_LEFT : RED;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Load / saturating-decrement phase counter with a zero flag.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Intersection phase controller: rotates green among approaches with load and
// emergency selection, emergency preemption and green extension.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int N_APPR     = 4,
    parameter int GREEN_CYC  = 8,
    parameter int AMBER_CYC  = 3,
    parameter int ALLRED_CYC = 2,
    parameter int CNT_W      = 8,
    parameter int FREE_LEFT  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_APPR-1:0]         load_req,
    input  logic [N_APPR-1:0]         emerg_req,
    output logic [5*N_APPR-1:0]       lights,
    output logic [$clog2(N_APPR)-1:0] grant,
    output logic [1:0]                phase,
    output logic                      emerg_active
);

    localparam int               GW        = $clog2(N_APPR);
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] AMBER_LD  = CNT_W'(AMBER_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [4:0]       RED_C     = red_code(FREE_LEFT != 0);

    phase_e              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic                emerg_q, emerg_d;
    logic [5*N_APPR-1:0] lights_q, lights_d;

    logic                tmr_load_s;
    logic [CNT_W-1:0]    tmr_val_s;
    logic [CNT_W-1:0]    tmr_cnt_s;
    logic                tmr_zero_s;
    logic [GW-1:0]       sel_idx_s;
    logic                sel_emerg_s;
    logic                grant_emerg_s;
    logic                preempt_s;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_LD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .cnt      (tmr_cnt_s),
        .zero     (tmr_zero_s)
    );

    // Selection: lowest emergency, else lowest load, else round-robin successor.
    always_comb begin
        sel_idx_s   = (grant_q == GW'(N_APPR - 1)) ? GW'(0) : grant_q + GW'(1);
        sel_emerg_s = 1'b0;
        for (int i = N_APPR - 1; i >= 0; i--) begin
            sel_idx_s = load_req[i] ? GW'(i) : sel_idx_s;
        end
        for (int i = N_APPR - 1; i >= 0; i--) begin
            sel_idx_s   = emerg_req[i] ? GW'(i) : sel_idx_s;
            sel_emerg_s = emerg_req[i] | sel_emerg_s;
        end
        grant_emerg_s = emerg_req[grant_q];
        preempt_s     = (emerg_req != '0) && !grant_emerg_s;
    end

    // Phase sequencing; extension falls out of the timer saturating at zero.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        emerg_d    = emerg_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = ALLRED_LD;
        case (state_q)
            PH_ALL_RED: begin
                if (tmr_zero_s) begin
                    state_d    = PH_GREEN;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = GREEN_LD;
                    grant_d    = sel_idx_s;
                    emerg_d    = sel_emerg_s;
                end else begin
                    state_d = PH_ALL_RED;
                end
            end
            PH_GREEN: begin
                if (preempt_s || (tmr_zero_s && !grant_emerg_s)) begin
                    state_d    = PH_AMBER;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = AMBER_LD;
                end else begin
                    state_d = PH_GREEN;
                end
            end
            PH_AMBER: begin
                if (tmr_zero_s) begin
                    state_d    = PH_ALL_RED;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = ALLRED_LD;
                    emerg_d    = 1'b0;
                end else begin
                    state_d = PH_AMBER;
                end
            end
            default: begin
                state_d    = PH_ALL_RED;
                tmr_load_s = 1'b1;
                tmr_val_s  = ALLRED_LD;
                emerg_d    = 1'b0;
            end
        endcase
    end

    // Lights are decoded from the next state so the register lines up with the phase.
    always_comb begin
        lights_d = '0;
        for (int i = 0; i < N_APPR; i++) begin
            if (grant_d == GW'(i) && state_d == PH_GREEN) begin
                lights_d[5*i +: 5] = GREEN_ALL;
            end else if (grant_d == GW'(i) && state_d == PH_AMBER) begin
                lights_d[5*i +: 5] = AMBER;
            end else begin
                lights_d[5*i +: 5] = RED_C;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= PH_ALL_RED;
            grant_q  <= GW'(N_APPR - 1);
            emerg_q  <= 1'b0;
            lights_q <= {N_APPR{RED_C}};
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            emerg_q  <= emerg_d;
            lights_q <= lights_d;
        end
    end

    assign lights       = lights_q;
    assign grant        = grant_q;
    assign phase        = state_q;
    assign emerg_active = emerg_q;

endmodule
